stage_sequencer: RTL

Generates the one-hot stage enables (fetch, decode, execute, memory, writeback) that step the five-stage multi-cycle CPU datapath, replacing the free-running stage rotation. It adds run/halt control, single-step, a memory-stage stall (`mem_wait`) with timeout, and a retired-instruction counter. It sits at the CPU top level, driven by `sysclk`, and its enable outputs feed the stage modules and the UART clock input in place of the rotating phase registers.

---
 rtl/stage_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// One-hot stage enables for the multi-cycle CPU with run/halt, single-step and a counted retire; 1 cycle per stage, 5 per instruction.
// A mem_wait stall holds MEM one extra cycle per cycle asserted, up to STALL_TIMEOUT, then forces WB and latches a sticky timeout.
module stage_sequencer #(
    parameter int STALL_TIMEOUT = 255,
    parameter int CNT_W         = 32
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             mem_wait,
    output logic             fclk,
    output logic             dclk,
    output logic             eclk,
    output logic             mclk,
    output logic             wclk,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic             timeout
);

    typedef enum logic [5:0] {
        S_HALT   = 6'b000001,
        S_FETCH  = 6'b000010,
        S_DECODE = 6'b000100,
        S_EXEC   = 6'b001000,
        S_MEM    = 6'b010000,
        S_WB     = 6'b100000
    } state_t;

    localparam logic [15:0] STALL_LIMIT = 16'(STALL_TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;
    logic        timeout_nxt;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= S_HALT;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            timeout  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = timeout;
        case (state)
            S_HALT: begin
                if (!timeout && (run || step)) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                state_nxt    = S_MEM;
                wait_cnt_nxt = '0;
            end
            S_MEM: begin
                if (!mem_wait) begin
                    state_nxt = S_WB;
                end else if (wait_cnt < STALL_LIMIT) begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end else begin
                    // Give up on the stalled access; the instruction still retires.
                    state_nxt   = S_WB;
                    timeout_nxt = 1'b1;
                end
            end
            S_WB: begin
                // timeout is already registered by the time WB is reached.
                if (run && !timeout) begin
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_HALT;
                end
            end
            default: state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            retired <= '0;
        end else if (state == S_WB) begin
            retired <= retired + CNT_W'(1);
        end
    end

    assign halted = state[0];
    assign fclk   = state[1];
    assign dclk   = state[2];
    assign eclk   = state[3];
    assign mclk   = state[4];
    assign wclk   = state[5];

endmodule
